dcm_prog_serializer: RTL
========================

Name: dcm_prog_serializer

Overview:
- Downstream of the DCM command/controller stage. Takes one {M-1, D-1} configuration word over a valid/ready handshake.
- Drives the DCM_CLKGEN PROGEN/PROGDATA serial protocol: LoadD, LoadM, then GO. It then waits for PROGDONE and reports completion.
- Runs on the DCM programming clock. Replaces the ad-hoc state counter with a clean, resettable, handshaked engine.

Parameters:
- GAP_CYCLES, 2, number of idle cycles (PROGEN=0) after each load command; legal range 1..15.
- TIMEOUT_CYCLES, 65535, PROGDONE watchdog limit in clk cycles; used only with DCM_PROG_TIMEOUT_EN.

Ports:
- clk  in  1  DCM programming clock (PROGCLK); all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration word offered.
- cfg_ready  out  1  engine idle and able to accept a word.
- cfg_mult_m1  in  8  multiplier minus one (M-1).
- cfg_div_m1  in  8  divider minus one (D-1).
- prog_en  out  1  to DCM PROGEN.
- prog_data  out  1  to DCM PROGDATA.
- prog_done  in  1  from DCM PROGDONE.
- busy  out  1  high from acceptance until completion or error.
- done_pulse  out  1  one-cycle pulse when PROGDONE handshake completes.
- timeout_err  out  1  sticky watchdog error; constant 0 without DCM_PROG_TIMEOUT_EN.

Behaviour:
- Reset values: cfg_ready=0 while reset_n low, 1 in IDLE thereafter. prog_en=0, prog_data=0, busy=0, done_pulse=0, timeout_err=0, state=IDLE, counters=0.
- All outputs are registered. cfg_ready = (state==IDLE), registered.
- Handshake: a word is accepted on a cycle where cfg_valid && cfg_ready. Both fields are latched into a 16-bit shift register {M-1, D-1}. cfg_valid while not ready is ignored; the upstream stage holds it.
- States and transitions:
  - IDLE: on accept, go to LOAD_D. prog_en/prog_data driven in LOAD_D starting the cycle after accept.
  - LOAD_D: 10 cycles with prog_en=1. prog_data = 1, 0, then D-1 bits LSB first. Then go to GAP_D.
  - GAP_D: GAP_CYCLES cycles with prog_en=0, prog_data=0. Then go to LOAD_M.
  - LOAD_M: 10 cycles with prog_en=1. prog_data = 1, 1, then M-1 bits LSB first. Then go to GAP_M.
  - GAP_M: GAP_CYCLES cycles with prog_en=0, prog_data=0. Then go to GO.
  - GO: 1 cycle with prog_en=1, prog_data=0. Then go to WAIT_LOW.
  - WAIT_LOW: prog_en=0. Wait until prog_done is sampled 0, which guarantees the GO was recognised. Then go to WAIT_HIGH.
  - WAIT_HIGH: prog_en=0. On prog_done sampled 1, assert done_pulse for 1 cycle, drop busy the same cycle, and go to IDLE.
- Bit counter: 4-bit, counts 0..9 in the load states; the shift register shifts right 1 per data bit.
- Latency from accept to GO = 1 + 10 + GAP + 10 + GAP cycles. With default GAP_CYCLES=2 that is 25 cycles, so GO is output in cycle 26 after accept.
- Values are not range-checked. Clamping (M 2..max) is the upstream stage's job. 8'h00 and 8'hFF are serialized verbatim.
- prog_done already high when the engine enters WAIT_LOW: the engine stays in WAIT_LOW until prog_done goes low; it never completes early.
- Asynchronous reset mid-sequence: immediate return to IDLE with prog_en=0. After release, the DCM is not guaranteed consistent; the upstream stage must re-issue the word.

Optional Feature:
- Macro DCM_PROG_TIMEOUT_EN.
- Defined: a 16-bit counter runs in WAIT_LOW/WAIT_HIGH and clears on entry. If it reaches TIMEOUT_CYCLES:
  - timeout_err is set (sticky until reset);
  - busy drops and the engine goes to IDLE;
  - done_pulse is not asserted.
  - A later accepted word clears nothing; only reset_n clears timeout_err.
- Undefined: no counter; WAIT states wait indefinitely; timeout_err is tied to 0.

Decomposition:
- Shared package dcm_pkg:
  - state encoding localparams (IDLE..WAIT_HIGH, 4-bit);
  - command bit pairs CMD_LOAD_D=2'b01 and CMD_LOAD_M=2'b11 (sent LSB first);
  - LOAD_LEN=10.
- No sub-module is needed. The single FSM plus shift register and counters is self-contained.

Test Plan:
- Reset, then cfg_valid with M-1=0x0F, D-1=0x07:
  - prog_data in LOAD_D = 1,0,1,1,1,0,0,0,0,0;
  - GAP 2 cycles of 0;
  - LOAD_M = 1,1,1,1,1,1,0,0,0,0;
  - GO (en=1, data=0) at cycle 26.
  - Then prog_done low, high 5 cycles later: done_pulse exactly 1 cycle; cfg_ready=1 the next cycle.
- Word offered while busy: cfg_ready=0; held cfg_valid is accepted only after done_pulse, and its bits appear serialized from the next sequence.
- prog_done stuck high through GO: engine stays in WAIT_LOW, busy=1, no done_pulse. Drive low then high: completes normally.
- reset_n asserted during LOAD_M bit 5: prog_en=0 immediately. After release, cfg_ready=1 and busy=0.
- With DCM_PROG_TIMEOUT_EN and TIMEOUT_CYCLES=100, prog_done held low: timeout_err=1 after 100 wait cycles, busy=0, no done_pulse. timeout_err remains 1 across a subsequent successful sequence.
- Edge values: M-1=0xFF, D-1=0x00 serialize as eight 1s and eight 0s respectively. GAP_CYCLES=1 gives GO at cycle 24.

Source files
------------

// File: rtl/dcm_prog_serializer_pkg.sv
// dcm_pkg: shared state encoding and protocol constants for the DCM_CLKGEN programming engine.
package dcm_pkg;
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_D    = 4'd1,
        GAP_D     = 4'd2,
        LOAD_M    = 4'd3,
        GAP_M     = 4'd4,
        GO        = 4'd5,
        WAIT_LOW  = 4'd6,
        WAIT_HIGH = 4'd7
    } state_e;
    localparam logic [1:0] CMD_LOAD_D = 2'b01;
    localparam logic [1:0] CMD_LOAD_M = 2'b11;
    localparam int         LOAD_LEN   = 10;
endpackage

// File: rtl/dcm_prog_serializer_if.sv
// dcm_prog_serializer_if: valid/ready configuration word channel {M-1, D-1}.
interface dcm_prog_serializer_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_mult_m1;
    logic [7:0] cfg_div_m1;
    modport master (output cfg_valid, cfg_mult_m1, cfg_div_m1, input cfg_ready);
    modport slave  (input cfg_valid, cfg_mult_m1, cfg_div_m1, output cfg_ready);
endinterface

// File: rtl/dcm_prog_serializer.sv
// dcm_prog_serializer: handshaked PROGEN/PROGDATA engine (LoadD, LoadM, GO, PROGDONE wait).
// Optional PROGDONE watchdog enabled by defining DCM_PROG_TIMEOUT_EN.
module dcm_prog_serializer
    import dcm_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         reset_n,
    dcm_prog_serializer_if.slave         cfg,
    output logic                         prog_en,
    output logic                         prog_data,
    input  logic                         prog_done,
    output logic                         busy,
    output logic                         done_pulse,
    output logic                         timeout_err
);
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] sr_q, sr_d;
    logic        en_q, en_d, dat_q, dat_d, done_q, done_d, busy_q, ready_q, te_q, te_d;
    logic [1:0]  cmd;
    logic        accept, is_d, last_bit, last_gap;
`ifdef DCM_PROG_TIMEOUT_EN
    logic [15:0] tmr_q, tmr_d;
`endif

    assign accept   = cfg.cfg_valid && ready_q;
    assign is_d     = (state_q == LOAD_D) || (state_q == GAP_D);
    assign cmd      = (state_q == LOAD_D) ? CMD_LOAD_D : CMD_LOAD_M;
    assign last_bit = cnt_q == 4'(LOAD_LEN - 1);
    assign last_gap = cnt_q == 4'(GAP_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        en_d    = 1'b0;
        dat_d   = 1'b0;
        done_d  = 1'b0;
        te_d    = te_q;
`ifdef DCM_PROG_TIMEOUT_EN
        tmr_d   = tmr_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                sr_d    = {cfg.cfg_mult_m1, cfg.cfg_div_m1};
                cnt_d   = '0;
                state_d = LOAD_D;
            end
            LOAD_D, LOAD_M: begin
                en_d    = 1'b1;
                // two command bits first, then the latched field straight off the shifter
                dat_d   = (cnt_q < 4'd2) ? cmd[cnt_q[0]] : sr_q[0];
                sr_d    = (cnt_q < 4'd2) ? sr_q : sr_q >> 1;
                cnt_d   = last_bit ? 4'd0 : cnt_q + 4'd1;
                state_d = !last_bit ? state_q : is_d ? GAP_D : GAP_M;
            end
            GAP_D, GAP_M: begin
                cnt_d   = last_gap ? 4'd0 : cnt_q + 4'd1;
                state_d = !last_gap ? state_q : is_d ? LOAD_M : GO;
            end
            GO: begin
                en_d    = 1'b1;
                state_d = WAIT_LOW;
`ifdef DCM_PROG_TIMEOUT_EN
                tmr_d   = '0;
`endif
            end
            WAIT_LOW: state_d = prog_done ? WAIT_LOW : WAIT_HIGH;
            WAIT_HIGH: begin
                done_d  = prog_done;
                state_d = prog_done ? IDLE : WAIT_HIGH;
            end
            default: state_d = IDLE;
        endcase
`ifdef DCM_PROG_TIMEOUT_EN
        if (state_q == WAIT_LOW || state_q == WAIT_HIGH) begin
            tmr_d = tmr_q + 16'd1;
            if (tmr_q == 16'(TIMEOUT_CYCLES - 1)) begin
                te_d    = 1'b1;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            en_q    <= 1'b0;
            dat_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            te_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            en_q    <= en_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            busy_q  <= state_d != IDLE;
            ready_q <= state_d == IDLE;
            te_q    <= te_d;
        end
    end

`ifdef DCM_PROG_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmr_q <= '0;
        else          tmr_q <= tmr_d;
    end
`endif

    assign cfg.cfg_ready = ready_q;
    assign prog_en       = en_q;
    assign prog_data     = dat_q;
    assign busy          = busy_q;
    assign done_pulse    = done_q;
    assign timeout_err   = te_q;
endmodule
